mem_access_unit: RTL and testbench

//  MEM-stage data-memory access engine; sits between the EX/MEM pipeline register and mem_wb.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/load_store_align.sv | 45 ++++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory access path.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'b00,
        MAU_BUSY = 2'b01,
        MAU_DONE = 2'b10
    } mau_state_t;

    // The reserved encoding behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? MEM_W : size;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            MEM_B:   be = 4'b0001 << offset;
            MEM_H:   be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = offset[0];
            default: bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables and replicated store data on the way out,
// lane extraction and sign/zero extension of the read word on the way back.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_word,
    output logic        misaligned
);

    logic [1:0]  eff_size;
    logic [31:0] shifted;

    always_comb begin
        eff_size   = norm_size(size);
        be         = lane_be(eff_size, offset);
        misaligned = is_misaligned(eff_size, offset);
        shifted    = rdata >> {offset, 3'b000};
        wdata      = store_data;
        load_word  = rdata;
        case (eff_size)
            MEM_B: begin
                wdata     = {4{store_data[7:0]}};
                load_word = is_unsigned ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_H: begin
                wdata     = {2{store_data[15:0]}};
                load_word = is_unsigned ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata     = store_data;
                load_word = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access engine: turns an EX/MEM load/store into one handshaked RAM transaction,
// stalling the pipeline until the RAM acknowledges or the wait times out.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead_ex_mem,
    input  logic              MemWrite_ex_mem,
    input  logic [1:0]        mem_size_ex_mem,
    input  logic              mem_unsigned_ex_mem,
    input  logic [31:0]       alu_out_ex_mem,
    input  logic [31:0]       store_data_ex_mem,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic              ram_ack,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       ram_read_data_mem,
    output logic              mem_stall,
    output logic              addr_err,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mau_state_t  state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]  req_size;
    logic [1:0]  req_offset;
    logic        req_unsigned;

    logic        access;
    logic        timeout;
    logic [1:0]  align_size;
    logic [1:0]  align_offset;
    logic        align_unsigned;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        align_misaligned;

    assign access  = MemRead_ex_mem | MemWrite_ex_mem;
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // While waiting on the RAM, extraction uses the attributes latched at accept time.
    assign align_size     = (state == MAU_IDLE) ? mem_size_ex_mem     : req_size;
    assign align_offset   = (state == MAU_IDLE) ? alu_out_ex_mem[1:0] : req_offset;
    assign align_unsigned = (state == MAU_IDLE) ? mem_unsigned_ex_mem : req_unsigned;

    load_store_align u_align (
        .size        (align_size),
        .offset      (align_offset),
        .is_unsigned (align_unsigned),
        .store_data  (store_data_ex_mem),
        .rdata       (ram_rdata),
        .be          (align_be),
        .wdata       (align_wdata),
        .load_word   (align_load),
        .misaligned  (align_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MAU_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_stall  = 1'b0;
        case (state)
            MAU_IDLE: begin
                if (access && !align_misaligned) begin
                    mem_stall  = 1'b1;
                    next_state = MAU_BUSY;
                end
            end
            MAU_BUSY: begin
                mem_stall = 1'b1;
                if (ram_ack || timeout) next_state = MAU_DONE;
            end
            MAU_DONE: next_state = MAU_IDLE;
            default:  next_state = MAU_IDLE;
        endcase
    end

    // Request fields stay frozen from accept until ack/timeout; error flags are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_req           <= 1'b0;
            ram_we            <= 1'b0;
            ram_addr          <= '0;
            ram_wdata         <= '0;
            ram_be            <= '0;
            ram_read_data_mem <= '0;
            addr_err          <= 1'b0;
            bus_err           <= 1'b0;
            wait_cnt          <= '0;
            req_size          <= '0;
            req_offset        <= '0;
            req_unsigned      <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                MAU_IDLE: begin
                    if (access) begin
                        if (align_misaligned) begin
                            addr_err          <= 1'b1;
                            ram_read_data_mem <= '0;
                        end else begin
                            ram_req      <= 1'b1;
                            ram_we       <= MemWrite_ex_mem;
                            ram_addr     <= {alu_out_ex_mem[ADDR_W-1:2], 2'b00};
                            ram_be       <= align_be;
                            ram_wdata    <= align_wdata;
                            wait_cnt     <= '0;
                            req_size     <= mem_size_ex_mem;
                            req_offset   <= alu_out_ex_mem[1:0];
                            req_unsigned <= mem_unsigned_ex_mem;
                        end
                    end
                end
                MAU_BUSY: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        if (!ram_we) ram_read_data_mem <= align_load;
                    end else if (timeout) begin
                        ram_req           <= 1'b0;
                        bus_err           <= 1'b1;
                        ram_read_data_mem <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a scripted RAM acks after a chosen delay (or never)
// and each scenario task checks stall length, RAM request fields, result and error pulses.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead_ex_mem = 1'b0;
    logic        MemWrite_ex_mem = 1'b0;
    logic [1:0]  mem_size_ex_mem = 2'b00;
    logic        mem_unsigned_ex_mem = 1'b0;
    logic [31:0] alu_out_ex_mem = '0;
    logic [31:0] store_data_ex_mem = '0;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic [31:0] ram_read_data_mem;
    logic        mem_stall;
    logic        addr_err;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    int          stall_cnt, req_cnt, aerr_cnt, berr_cnt;
    logic        stall_at_berr;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;
    logic [31:0] seen_addr;
    logic        seen_we;

    mem_access_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .MemRead_ex_mem      (MemRead_ex_mem),
        .MemWrite_ex_mem     (MemWrite_ex_mem),
        .mem_size_ex_mem     (mem_size_ex_mem),
        .mem_unsigned_ex_mem (mem_unsigned_ex_mem),
        .alu_out_ex_mem      (alu_out_ex_mem),
        .store_data_ex_mem   (store_data_ex_mem),
        .ram_req             (ram_req),
        .ram_we              (ram_we),
        .ram_addr            (ram_addr),
        .ram_wdata           (ram_wdata),
        .ram_be              (ram_be),
        .ram_ack             (ram_ack),
        .ram_rdata           (ram_rdata),
        .ram_read_data_mem   (ram_read_data_mem),
        .mem_stall           (mem_stall),
        .addr_err            (addr_err),
        .bus_err             (bus_err)
    );

    always #5 clk = ~clk;

    // Presents one instruction and plays the RAM for a fixed number of cycles; the request
    // is withdrawn after the first cycle the pipeline is allowed to advance.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int ack_delay, input int n_cycles);
        logic advanced;
        advanced = 1'b0;
        stall_cnt = 0; req_cnt = 0; aerr_cnt = 0; berr_cnt = 0;
        stall_at_berr = 1'b0;
        seen_be = 'x; seen_wdata = 'x; seen_addr = 'x; seen_we = 1'bx;
        MemRead_ex_mem      = rd;
        MemWrite_ex_mem     = wr;
        mem_size_ex_mem     = size;
        mem_unsigned_ex_mem = uns;
        alu_out_ex_mem      = addr;
        store_data_ex_mem   = sdata;
        for (int c = 0; c < n_cycles; c++) begin
            #1;
            if (ram_req === 1'b1) begin
                if (req_cnt == 0) begin
                    seen_be = ram_be; seen_wdata = ram_wdata;
                    seen_addr = ram_addr; seen_we = ram_we;
                end
                if (req_cnt == ack_delay) begin
                    ram_ack   = 1'b1;
                    ram_rdata = rdata;
                end
                req_cnt++;
            end
            if (mem_stall === 1'b1) stall_cnt++;
            else advanced = 1'b1;
            if (addr_err === 1'b1) aerr_cnt++;
            if (bus_err === 1'b1) begin
                berr_cnt++;
                if (mem_stall !== 1'b0) stall_at_berr = 1'b1;
            end
            @(posedge clk); #1;
            ram_ack = 1'b0;
            if (advanced) begin
                MemRead_ex_mem  = 1'b0;
                MemWrite_ex_mem = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++; if (ram_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req: got %b expected 0", ram_req); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("[TB] FAIL reset_we: got %b expected 0", ram_we); end
        n_cmp++; if (ram_addr !== 32'h0) begin n_err++; $display("[TB] FAIL reset_addr: got %h expected 0", ram_addr); end
        n_cmp++; if (ram_wdata !== 32'h0) begin n_err++; $display("[TB] FAIL reset_wdata: got %h expected 0", ram_wdata); end
        n_cmp++; if (ram_be !== 4'h0) begin n_err++; $display("[TB] FAIL reset_be: got %h expected 0", ram_be); end
        n_cmp++; if (ram_read_data_mem !== 32'h0) begin n_err++; $display("[TB] FAIL reset_result: got %h expected 0", ram_read_data_mem); end
        n_cmp++; if ({mem_stall, addr_err, bus_err} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_flags: got %b expected 000", {mem_stall, addr_err, bus_err}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h12345678, 2, 8);
        n_cmp++; if (stall_cnt !== 4) begin n_err++; $display("[TB] FAIL lw_stall_cycles: got %0d expected 4", stall_cnt); end
        n_cmp++; if (req_cnt !== 3) begin n_err++; $display("[TB] FAIL lw_req_cycles: got %0d expected 3", req_cnt); end
        n_cmp++; if (seen_be !== 4'hF) begin n_err++; $display("[TB] FAIL lw_be: got %h expected f", seen_be); end
        n_cmp++; if (seen_addr !== 32'h100) begin n_err++; $display("[TB] FAIL lw_addr: got %h expected 00000100", seen_addr); end
        n_cmp++; if (seen_we !== 1'b0) begin n_err++; $display("[TB] FAIL lw_we: got %b expected 0", seen_we); end
        n_cmp++; if (ram_read_data_mem !== 32'h12345678) begin n_err++; $display("[TB] FAIL lw_result: got %h expected 12345678", ram_read_data_mem); end
    endtask

    task automatic test_load_byte;
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1, 8);
        n_cmp++; if (seen_be !== 4'b1000) begin n_err++; $display("[TB] FAIL lb_be: got %b expected 1000", seen_be); end
        n_cmp++; if (seen_addr !== 32'h100) begin n_err++; $display("[TB] FAIL lb_addr: got %h expected 00000100", seen_addr); end
        n_cmp++; if (ram_read_data_mem !== 32'hFFFFFF80) begin n_err++; $display("[TB] FAIL lb_result: got %h expected ffffff80", ram_read_data_mem); end
        run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 8);
        n_cmp++; if (stall_cnt !== 2) begin n_err++; $display("[TB] FAIL lbu_stall_cycles: got %0d expected 2", stall_cnt); end
        n_cmp++; if (ram_read_data_mem !== 32'h00000080) begin n_err++; $display("[TB] FAIL lbu_result: got %h expected 00000080", ram_read_data_mem); end
    endtask

    task automatic test_store;
        run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 32'h55555555, 1, 8);
        n_cmp++; if (seen_we !== 1'b1) begin n_err++; $display("[TB] FAIL sh_we: got %b expected 1", seen_we); end
        n_cmp++; if (seen_be !== 4'b1100) begin n_err++; $display("[TB] FAIL sh_be: got %b expected 1100", seen_be); end
        n_cmp++; if (seen_wdata !== 32'hBEEFBEEF) begin n_err++; $display("[TB] FAIL sh_wdata: got %h expected beefbeef", seen_wdata); end
        n_cmp++; if (seen_addr !== 32'h200) begin n_err++; $display("[TB] FAIL sh_addr: got %h expected 00000200", seen_addr); end
        n_cmp++; if (ram_read_data_mem !== 32'h00000080) begin n_err++; $display("[TB] FAIL sh_result_kept: got %h expected 00000080", ram_read_data_mem); end
        run_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h301, 32'h123456A5, 32'h0, 0, 8);
        n_cmp++; if (seen_we !== 1'b1) begin n_err++; $display("[TB] FAIL sb_both_we: got %b expected 1", seen_we); end
        n_cmp++; if (seen_be !== 4'b0010) begin n_err++; $display("[TB] FAIL sb_be: got %b expected 0010", seen_be); end
        n_cmp++; if (seen_wdata !== 32'hA5A5A5A5) begin n_err++; $display("[TB] FAIL sb_wdata: got %h expected a5a5a5a5", seen_wdata); end
    endtask

    task automatic test_misaligned;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hFFFFFFFF, 0, 6);
        n_cmp++; if (req_cnt !== 0) begin n_err++; $display("[TB] FAIL mis_lw_req: got %0d expected 0", req_cnt); end
        n_cmp++; if (stall_cnt !== 0) begin n_err++; $display("[TB] FAIL mis_lw_stall: got %0d expected 0", stall_cnt); end
        n_cmp++; if (aerr_cnt !== 1) begin n_err++; $display("[TB] FAIL mis_lw_addr_err: got %0d expected 1", aerr_cnt); end
        n_cmp++; if (ram_read_data_mem !== 32'h0) begin n_err++; $display("[TB] FAIL mis_lw_result: got %h expected 0", ram_read_data_mem); end
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 32'h80010000, 0, 8);
        n_cmp++; if (seen_be !== 4'b1100) begin n_err++; $display("[TB] FAIL lhu_be: got %b expected 1100", seen_be); end
        n_cmp++; if (ram_read_data_mem !== 32'h00008001) begin n_err++; $display("[TB] FAIL lhu_result: got %h expected 00008001", ram_read_data_mem); end
        run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h102, 32'h0, 32'h0, 0, 6);
        n_cmp++; if (req_cnt !== 0 || aerr_cnt !== 1) begin n_err++; $display("[TB] FAIL mis_reserved: got req=%0d aerr=%0d expected req=0 aerr=1", req_cnt, aerr_cnt); end
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 32'h80010000, 0, 8);
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, -1, 24);
        n_cmp++; if (req_cnt !== 16) begin n_err++; $display("[TB] FAIL to_req_cycles: got %0d expected 16", req_cnt); end
        n_cmp++; if (stall_cnt !== 17) begin n_err++; $display("[TB] FAIL to_stall_cycles: got %0d expected 17", stall_cnt); end
        n_cmp++; if (berr_cnt !== 1) begin n_err++; $display("[TB] FAIL to_bus_err: got %0d expected 1", berr_cnt); end
        n_cmp++; if (stall_at_berr !== 1'b0) begin n_err++; $display("[TB] FAIL to_stall_at_err: got %b expected 0", stall_at_berr); end
        n_cmp++; if (ram_read_data_mem !== 32'h0) begin n_err++; $display("[TB] FAIL to_result: got %h expected 0", ram_read_data_mem); end
    endtask

    task automatic test_reset_in_busy;
        MemRead_ex_mem  = 1'b1;
        mem_size_ex_mem = 2'b10;
        alu_out_ex_mem  = 32'h500;
        @(posedge clk); #1;
        n_cmp++; if (ram_req !== 1'b1) begin n_err++; $display("[TB] FAIL rb_req_before: got %b expected 1", ram_req); end
        @(posedge clk); #1;
        rst = 1'b1;
        MemRead_ex_mem = 1'b0;
        #1;
        n_cmp++; if (ram_req !== 1'b0) begin n_err++; $display("[TB] FAIL rb_req_dropped: got %b expected 0", ram_req); end
        n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("[TB] FAIL rb_stall_dropped: got %b expected 0", mem_stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h004, 32'h0, 32'h1234ABCD, 0, 8);
        n_cmp++; if (stall_cnt !== 2) begin n_err++; $display("[TB] FAIL rb_lh_stall: got %0d expected 2", stall_cnt); end
        n_cmp++; if (seen_be !== 4'b0011) begin n_err++; $display("[TB] FAIL rb_lh_be: got %b expected 0011", seen_be); end
        n_cmp++; if (ram_read_data_mem !== 32'hFFFFABCD) begin n_err++; $display("[TB] FAIL rb_lh_result: got %h expected ffffabcd", ram_read_data_mem); end
    endtask

    task automatic test_idle_ack_ignored;
        ram_ack   = 1'b1;
        ram_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        n_cmp++; if (ram_read_data_mem !== 32'hFFFFABCD) begin n_err++; $display("[TB] FAIL idle_ack_result: got %h expected ffffabcd", ram_read_data_mem); end
        n_cmp++; if ({ram_req, mem_stall} !== 2'b00) begin n_err++; $display("[TB] FAIL idle_ack_state: got %b expected 00", {ram_req, mem_stall}); end
    endtask

    initial begin
        $display("[TB] starting mem_access_unit bench");
        test_reset;
        test_load_word;
        test_load_byte;
        test_store;
        test_misaligned;
        test_timeout;
        test_reset_in_busy;
        test_idle_ack_ignored;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
